// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : UART transmitter with an input FIFO. Words pushed over a
//             valid/ready handshake are sent as start, data LSB-first,
//             optional parity and 1 or 2 stop bits.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 347,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 2,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [DATA_BITS-1:0]              tx_data,
   input  logic                              tx_valid,
   output logic                              tx_ready,
   output logic                              TxD,
   output logic                              busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

   localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int c_ptr_w = $clog2(FIFO_DEPTH);
   localparam int c_lvl_w = $clog2(FIFO_DEPTH+1);
   localparam int c_idx_w = 4;

   localparam logic [c_cnt_w-1:0] c_cnt_max   = c_cnt_w'(CLKS_PER_BIT - 1);
   localparam logic [c_lvl_w-1:0] c_full      = c_lvl_w'(FIFO_DEPTH);
   localparam logic [c_idx_w-1:0] c_last_data = c_idx_w'(DATA_BITS - 1);
   localparam logic [c_idx_w-1:0] c_last_stop = c_idx_w'(STOP_BITS - 1);

   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_start  = 3'd1;
   localparam logic [2:0] c_st_data   = 3'd2;
   localparam logic [2:0] c_st_parity = 3'd3;
   localparam logic [2:0] c_st_stop   = 3'd4;

   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [c_lvl_w-1:0]   r_level;

   logic [2:0]           r_state;
   logic [2:0]           w_state_nxt;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [c_idx_w-1:0]   r_bit_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par;
   logic                 r_txd;

   logic                 w_ready;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_not_empty;
   logic                 w_bit_end;
   logic                 w_last_data;
   logic                 w_last_stop;
   logic                 w_txd;
   logic [DATA_BITS-1:0] w_head;

   assign w_ready     = (r_level != c_full);
   assign w_push      = tx_valid && w_ready;
   assign w_not_empty = (r_level != '0);
   assign w_head      = r_mem[r_rd_ptr];
   assign w_bit_end   = (r_cnt == c_cnt_max);
   assign w_last_data = (r_bit_idx == c_last_data);
   assign w_last_stop = (r_bit_idx == c_last_stop);

   assign tx_ready   = w_ready;
   assign TxD        = r_txd;
   assign busy       = (r_state != c_st_idle) || w_not_empty;
   assign fifo_level = r_level;

   // FIFO storage: capture the word at push time
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= tx_data;
      end
   end

   // FIFO pointers and occupancy; push and pop together leave the level unchanged
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= c_st_idle;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic; the last stop bit chains straight into the next start bit
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle:   if (w_not_empty) w_state_nxt = c_st_start;
         c_st_start:  if (w_bit_end) w_state_nxt = c_st_data;
         c_st_data:   if (w_bit_end && w_last_data)
                         w_state_nxt = (PARITY != 0) ? c_st_parity : c_st_stop;
         c_st_parity: if (w_bit_end) w_state_nxt = c_st_stop;
         c_st_stop:   if (w_bit_end && w_last_stop)
                         w_state_nxt = w_not_empty ? c_st_start : c_st_idle;
         default:     w_state_nxt = c_st_idle;
      endcase
   end

   // Output decode: line level for the current state and the FIFO pop strobe
   always_comb begin
      w_txd = 1'b1;
      w_pop = 1'b0;
      case (r_state)
         c_st_idle:   w_pop = w_not_empty;
         c_st_start:  w_txd = 1'b0;
         c_st_data:   w_txd = r_shift[0];
         c_st_parity: w_txd = r_par;
         c_st_stop:   w_pop = w_bit_end && w_last_stop && w_not_empty;
         default:     w_txd = 1'b1;
      endcase
   end

   // Baud counter: held at zero in idle, restarts at every bit boundary
   always_ff @(posedge clk) begin
      if (rst || (r_state == c_st_idle) || w_bit_end) r_cnt <= '0;
      else                                            r_cnt <= r_cnt + 1'b1;
   end

   // Bit index over data and stop bits, cleared whenever the state changes
   always_ff @(posedge clk) begin
      if (rst || (w_state_nxt != r_state)) r_bit_idx <= '0;
      else if (w_bit_end)                  r_bit_idx <= r_bit_idx + 1'b1;
   end

   // Shift register and parity, both loaded from the FIFO head on pop
   always_ff @(posedge clk) begin
      if (w_pop) begin
         r_shift <= w_head;
         r_par   <= (^w_head) ^ (PARITY == 1);
      end else if ((r_state == c_st_data) && w_bit_end) begin
         r_shift <= r_shift >> 1;
      end
   end

   // Registered line driver, forced high by reset
   always_ff @(posedge clk) begin
      if (rst) r_txd <= 1'b1;
      else     r_txd <= w_txd;
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Directed self-checking bench for uart_tx_fifo using three
//             configurations: 8E1 depth 16, 7O2 depth 4, 8N1 depth 4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         tests = 0;
   int         fails = 0;

   logic [7:0] data_a = '0;
   logic       valid_a = 1'b0;
   logic       ready_a, txd_a, busy_a;
   logic [4:0] level_a;

   logic [6:0] data_b = '0;
   logic       valid_b = 1'b0;
   logic       ready_b, txd_b, busy_b;
   logic [2:0] level_b;

   logic [7:0] data_c = '0;
   logic       valid_c = 1'b0;
   logic       ready_c, txd_c, busy_c;
   logic [2:0] level_c;

   always #5 clk = ~clk;

   uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_a (
      .clk(clk), .rst(rst), .tx_data(data_a), .tx_valid(valid_a), .tx_ready(ready_a),
      .TxD(txd_a), .busy(busy_a), .fifo_level(level_a));

   uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
      .clk(clk), .rst(rst), .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b),
      .TxD(txd_b), .busy(busy_b), .fifo_level(level_b));

   uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
      .clk(clk), .rst(rst), .tx_data(data_c), .tx_valid(valid_c), .tx_ready(ready_c),
      .TxD(txd_c), .busy(busy_c), .fifo_level(level_c));

   function automatic logic txd_of(input int which);
      case (which)
         0:       return txd_a;
         1:       return txd_b;
         default: return txd_c;
      endcase
   endfunction

   // Start, 8 data LSB-first, even parity, one stop
   function automatic logic [10:0] frame_8e1(input logic [7:0] w);
      return {1'b1, ^w, w, 1'b0};
   endfunction

   // One-cycle push; caller sits 1 time unit after a rising edge
   task automatic push(input int which, input logic [7:0] d);
      case (which)
         0:       begin data_a = d;      valid_a = 1'b1; end
         1:       begin data_b = d[6:0]; valid_b = 1'b1; end
         default: begin data_c = d;      valid_c = 1'b1; end
      endcase
      @(posedge clk); #1;
      valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
   endtask

   // Checks nbits serial bits of 4 cycles each, starting at the next edge
   task automatic check_line(input int which, input logic [63:0] exp, input int nbits, input string name);
      for (int b = 0; b < nbits; b++) begin
         logic bad;
         logic seen;
         bad  = 1'b0;
         seen = exp[b];
         for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (txd_of(which) !== exp[b]) begin
               bad  = 1'b1;
               seen = txd_of(which);
            end
         end
         tests++;
         if (bad) begin
            fails++;
            $display("FAIL %s bit %0d: TxD=%b expected %b", name, b, seen, exp[b]);
         end
      end
   endtask

   task automatic test_reset();
      logic stuck;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      tests++; if (txd_a !== 1'b1)    begin fails++; $display("FAIL reset_txd: %b expected 1", txd_a); end
      tests++; if (ready_a !== 1'b1)  begin fails++; $display("FAIL reset_ready: %b expected 1", ready_a); end
      tests++; if (busy_a !== 1'b0)   begin fails++; $display("FAIL reset_busy: %b expected 0", busy_a); end
      tests++; if (level_a !== 5'd0)  begin fails++; $display("FAIL reset_level: %0d expected 0", level_a); end
      tests++; if ({txd_b, ready_b, busy_b, level_b} !== 6'b110000)
         begin fails++; $display("FAIL reset_b: txd/ready/busy/level=%b expected 110000", {txd_b, ready_b, busy_b, level_b}); end
      tests++; if ({txd_c, ready_c, busy_c, level_c} !== 6'b110000)
         begin fails++; $display("FAIL reset_c: txd/ready/busy/level=%b expected 110000", {txd_c, ready_c, busy_c, level_c}); end
      stuck = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (txd_a !== 1'b1 || busy_a !== 1'b0) stuck = 1'b1;
      end
      tests++; if (stuck) begin fails++; $display("FAIL idle_line: line left idle (1) with no push, got %b", txd_a); end
   endtask

   task automatic test_single_frame();
      push(0, 8'hA5);
      tests++; if (level_a !== 5'd1) begin fails++; $display("FAIL sf_level: %0d expected 1", level_a); end
      tests++; if (busy_a !== 1'b1)  begin fails++; $display("FAIL sf_busy_on: %b expected 1", busy_a); end
      tests++; if (txd_a !== 1'b1)   begin fails++; $display("FAIL sf_lat_n: TxD=%b expected 1", txd_a); end
      @(posedge clk); #1;
      tests++; if (txd_a !== 1'b1)   begin fails++; $display("FAIL sf_lat_n1: TxD=%b expected 1", txd_a); end
      check_line(0, 64'b10101001010, 11, "frame_a5");
      tests++; if (busy_a !== 1'b0)  begin fails++; $display("FAIL sf_busy_off: %b expected 0", busy_a); end
      tests++; if (level_a !== 5'd0) begin fails++; $display("FAIL sf_level_end: %0d expected 0", level_a); end
   endtask

   task automatic test_back_to_back();
      int   pushed;
      logic saw_full;
      logic bad_ready;
      pushed    = 0;
      saw_full  = 1'b0;
      bad_ready = 1'b0;
      fork
         begin
            data_a  = 8'h00;
            valid_a = 1'b1;
            for (int cyc = 0; cyc < 5000 && pushed < 32; cyc++) begin
               logic rdy;
               rdy = ready_a;
               @(posedge clk); #1;
               if (rdy) begin
                  pushed++;
                  data_a = 8'(pushed);
               end
               if (pushed >= 32) valid_a = 1'b0;
               if (level_a == 5'd16) saw_full = 1'b1;
               if ((level_a == 5'd16 && ready_a !== 1'b0) || (level_a < 5'd16 && ready_a !== 1'b1) || level_a > 5'd16)
                  bad_ready = 1'b1;
            end
            valid_a = 1'b0;
         end
         begin
            logic found;
            logic [10:0] fr;
            found = 1'b0;
            for (int i = 0; i < 10 && !found; i++) begin
               @(posedge clk); #1;
               if (txd_a === 1'b0) found = 1'b1;
            end
            tests++;
            if (!found) begin
               fails++; $display("FAIL b2b_start: TxD stayed %b, expected start bit 0", txd_a);
            end else begin
               for (int f = 0; f < 32; f++) begin
                  logic bad;
                  int   first_bad;
                  bad = 1'b0;
                  first_bad = 0;
                  fr = frame_8e1(8'(f));
                  for (int s = 0; s < 44; s++) begin
                     if (!(f == 0 && s == 0)) begin
                        @(posedge clk); #1;
                     end
                     if (txd_a !== fr[s/4] && !bad) begin
                        bad = 1'b1;
                        first_bad = s;
                     end
                  end
                  tests++;
                  if (bad) begin
                     fails++;
                     $display("FAIL b2b_frame %0d: cycle %0d TxD=%b expected %b", f, first_bad, txd_a, fr[first_bad/4]);
                  end
               end
            end
         end
      join
      tests++; if (pushed != 32)  begin fails++; $display("FAIL b2b_pushed: %0d expected 32", pushed); end
      tests++; if (!saw_full)     begin fails++; $display("FAIL b2b_full: level never reached 16 (flag %b expected 1)", saw_full); end
      tests++; if (bad_ready)     begin fails++; $display("FAIL b2b_ready: ready/level disagreement flag %b expected 0", bad_ready); end
      tests++; if (busy_a !== 1'b0 || level_a !== 5'd0)
         begin fails++; $display("FAIL b2b_end: busy=%b level=%0d expected 0/0", busy_a, level_a); end
   endtask

   task automatic test_odd_two_stop();
      push(1, 8'h00);
      @(posedge clk); #1;
      check_line(1, 64'b11100000000, 11, "b_frame_00");
      push(1, 8'h7F);
      @(posedge clk); #1;
      check_line(1, 64'b11011111110, 11, "b_frame_7f");
      tests++; if (busy_b !== 1'b0) begin fails++; $display("FAIL b_busy_end: %b expected 0", busy_b); end
   endtask

   task automatic test_reset_mid_frame();
      logic stray;
      push(0, 8'h11);
      push(0, 8'h22);
      push(0, 8'h33);
      repeat (8) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      tests++; if (txd_a !== 1'b1)    begin fails++; $display("FAIL rm_txd: %b expected 1", txd_a); end
      tests++; if (level_a !== 5'd0)  begin fails++; $display("FAIL rm_level: %0d expected 0", level_a); end
      tests++; if (busy_a !== 1'b0)   begin fails++; $display("FAIL rm_busy: %b expected 0", busy_a); end
      tests++; if (ready_a !== 1'b1)  begin fails++; $display("FAIL rm_ready: %b expected 1", ready_a); end
      stray = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (txd_a !== 1'b1 || busy_a !== 1'b0) stray = 1'b1;
      end
      tests++; if (stray) begin fails++; $display("FAIL rm_quiet: activity after reset flag %b expected 0", stray); end
      push(0, 8'h3C);
      @(posedge clk); #1;
      check_line(0, 64'b10001111000, 11, "frame_3c");
   endtask

   task automatic test_no_parity();
      push(2, 8'hFF);
      @(posedge clk); #1;
      check_line(2, 64'b1111111110, 10, "c_frame_ff");
      data_c  = 8'h0F;
      valid_c = 1'b1;
      @(posedge clk); #1;
      data_c  = 8'hF0;
      @(posedge clk); #1;
      valid_c = 1'b0;
      tests++; if (level_c !== 3'd1) begin fails++; $display("FAIL c_push_pop_level: %0d expected 1", level_c); end
      check_line(2, {44'b0, 10'b1111100000, 10'b1000011110}, 20, "c_pair");
      tests++; if (busy_c !== 1'b0) begin fails++; $display("FAIL c_busy_end: %b expected 0", busy_c); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog timeout");
   end

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_odd_two_stop();
      test_reset_mid_frame();
      test_no_parity();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
